pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
Central pipeline controller for the 5-stage core. It collects stall requests from ID (load-use) and EX (multi-cycle ALU ops such as divide), and flush requests from exception logic. It drives the per-stage hold vector used by pc_reg, if_id, id_ex, ex_mem and mem_wb. It sequences multi-cycle EX operations with a down-counter so id_ex holds its contents until the result is ready.

Parameters:
CNT_W, 6, width of the multi-cycle latency field and internal down-counter
PERF_W, 32, width of the saturating stall-cycle performance counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (rst==0 resets; assertion is asynchronous)
stallreq_id  input  1  ID load-use hazard request, level, combinational from ID
ex_mc_start  input  1  EX holds a new multi-cycle op this cycle; one-cycle pulse
ex_mc_cycles  input  CNT_W  latency N of that op; sampled only with ex_mc_start
flush_req  input  1  exception/flush request, level
stall  output  6  hold vector: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB
flush  output  1  clear all pipeline registers to NOP this cycle
ex_mc_done  output  1  one-cycle pulse: multi-cycle result valid in EX, op advances
busy  output  1  a multi-cycle op is in progress (MC_BUSY)
stall_cycles  output  PERF_W  count of cycles with stall!=0, saturating

Behaviour:
- FSM states: IDLE, MC_BUSY, MC_DONE, FLUSH. Internal counter cnt[CNT_W-1:0].
- Reset (rst==0, asynchronous): state=IDLE, cnt=0, stall_cycles=0. Decoded outputs follow from state: stall=0, flush=0, ex_mc_done=0, busy=0. Reset mid-operation aborts any multi-cycle op with no done pulse.
- Priority: flush_req > multi-cycle sequencing > stallreq_id.
- Stall decode (combinational):
  - flush_req=1, or state==FLUSH: stall=6'b000000.
  - state==MC_BUSY, or (state in {IDLE, MC_DONE} and ex_mc_start): stall=6'b001111.
  - otherwise, if stallreq_id=1: stall=6'b000111.
  - otherwise stall=0.
- flush=1 exactly when state==FLUSH. ex_mc_done=1 exactly when state==MC_DONE. busy=1 exactly when state==MC_BUSY.
- Transitions from IDLE and MC_DONE:
  - flush_req -> FLUSH.
  - else ex_mc_start with N>=2 -> MC_BUSY, cnt<=N-1.
  - else ex_mc_start with N in {0,1} -> MC_DONE.
  - else -> IDLE.
- Transitions from MC_BUSY:
  - flush_req -> FLUSH, cnt<=0; the op is aborted and no done pulse is issued.
  - else if cnt==1 -> MC_DONE.
  - else cnt<=cnt-1.
  - ex_mc_start is ignored in MC_BUSY.
- Transitions from FLUSH: flush_req still 1 -> stay in FLUSH; else -> IDLE. Inputs other than flush_req are ignored in FLUSH.
- Latency: an op with latency N holds EX for max(N,1) cycles (the start cycle plus N-1 MC_BUSY cycles). ex_mc_done follows in the next cycle. Max N = 2^CNT_W-1.
- stall_cycles increments each cycle in which stall!=0. It holds at 2^PERF_W-1 and never wraps.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs, release -> all outputs 0, state IDLE; assert rst=0 asynchronously between edges -> outputs clear without waiting for an edge.
- Load-use: stallreq_id=1 for 1 cycle in IDLE -> stall=000111 that cycle; stall_cycles becomes 1; next cycle stall=0.
- Divide: ex_mc_start with N=4 -> stall=001111 for 4 consecutive cycles, busy=1 for 3 of them; ex_mc_done=1 on the 5th cycle with stall=0; stall_cycles=4.
- Short op: N=0 and then N=1 -> each gives stall=001111 for 1 cycle, then ex_mc_done for 1 cycle, then IDLE.
- Flush: flush_req during MC_BUSY with cnt=2 -> stall=0 that cycle, flush=1 for exactly 1 cycle, no ex_mc_done; flush_req together with ex_mc_start in IDLE -> FLUSH wins and cnt stays 0.
- Saturation: PERF_W=4, stallreq_id held for 20 cycles -> stall_cycles reaches 15 and stays at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl_if.sv
// Request/response bundle between the pipeline stages and the stall controller.
// The pipeline side is the master; the controller is the slave.
interface pipe_stall_ctrl_if #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32
);
   logic              stallreq_id;
   logic              ex_mc_start;
   logic [CNT_W-1:0]  ex_mc_cycles;
   logic              flush_req;
   logic [5:0]        stall;
   logic              flush;
   logic              ex_mc_done;
   logic              busy;
   logic [PERF_W-1:0] stall_cycles;
   // Observation-only view of the controller FSM and its down-counter
   logic [1:0]        dbg_state;
   logic [CNT_W-1:0]  dbg_cnt;

   modport master (
      output stallreq_id, ex_mc_start, ex_mc_cycles, flush_req,
      input  stall, flush, ex_mc_done, busy, stall_cycles, dbg_state, dbg_cnt
   );

   modport slave (
      input  stallreq_id, ex_mc_start, ex_mc_cycles, flush_req,
      output stall, flush, ex_mc_done, busy, stall_cycles, dbg_state, dbg_cnt
   );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: merges load-use and
// multi-cycle EX stalls, sequences multi-cycle ops and counts stalled cycles.
module pipe_stall_ctrl #(
   parameter int CNT_W  = 6,
   parameter int PERF_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   pipe_stall_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MC_BUSY = 2'd1,
      ST_MC_DONE = 2'd2,
      ST_FLUSH   = 2'd3
   } state_t;

   localparam logic [PERF_W-1:0] PERF_MAX = '1;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [PERF_W-1:0]   r_perf;
   logic [5:0]          w_stall;
   logic                w_start_ok;

   // A new op is only accepted when no other op owns EX
   assign w_start_ok = ((r_state == ST_IDLE) || (r_state == ST_MC_DONE)) && bus.ex_mc_start;

   always_comb begin
      w_stall = 6'b000000;
      if (bus.flush_req || (r_state == ST_FLUSH)) begin
         w_stall = 6'b000000;
      end else if ((r_state == ST_MC_BUSY) || w_start_ok) begin
         w_stall = 6'b001111;
      end else if (bus.stallreq_id) begin
         w_stall = 6'b000111;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE, ST_MC_DONE: begin
            if (bus.flush_req) begin
               w_state_nxt = ST_FLUSH;
            end else if (bus.ex_mc_start) begin
               if (bus.ex_mc_cycles >= CNT_W'(2)) begin
                  w_state_nxt = ST_MC_BUSY;
                  w_cnt_nxt   = bus.ex_mc_cycles - CNT_W'(1);
               end else begin
                  w_state_nxt = ST_MC_DONE;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_MC_BUSY: begin
            // Flush aborts the op outright; no done pulse follows
            if (bus.flush_req) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = '0;
            end else begin
               if (r_cnt == CNT_W'(1)) begin
                  w_state_nxt = ST_MC_DONE;
               end
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            w_state_nxt = bus.flush_req ? ST_FLUSH : ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_perf <= '0;
      end else if ((w_stall != 6'b000000) && (r_perf != PERF_MAX)) begin
         r_perf <= r_perf + PERF_W'(1);
      end
   end

   assign bus.stall        = w_stall;
   assign bus.flush        = (r_state == ST_FLUSH);
   assign bus.ex_mc_done   = (r_state == ST_MC_DONE);
   assign bus.busy         = (r_state == ST_MC_BUSY);
   assign bus.stall_cycles = r_perf;
   assign bus.dbg_state    = r_state;
   assign bus.dbg_cnt      = r_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a default instance plus a PERF_W=4
// instance sharing the same stimulus for the saturation check.
module tb_pipe_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       tb_id;
   logic       tb_start;
   logic [5:0] tb_n;
   logic       tb_fl;
   int         total = 0;
   int         bad   = 0;

   pipe_stall_ctrl_if #(.CNT_W(6), .PERF_W(32)) bus ();
   pipe_stall_ctrl_if #(.CNT_W(6), .PERF_W(4))  bus_s ();

   assign bus.stallreq_id    = tb_id;
   assign bus.ex_mc_start    = tb_start;
   assign bus.ex_mc_cycles   = tb_n;
   assign bus.flush_req      = tb_fl;
   assign bus_s.stallreq_id  = tb_id;
   assign bus_s.ex_mc_start  = tb_start;
   assign bus_s.ex_mc_cycles = tb_n;
   assign bus_s.flush_req    = tb_fl;

   pipe_stall_ctrl #(.CNT_W(6), .PERF_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipe_stall_ctrl #(.CNT_W(6), .PERF_W(4)) dut_s (
      .clk (clk),
      .rst (rst),
      .bus (bus_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge and settle before checking
   task automatic cyc(input logic id, input logic st, input logic [5:0] n, input logic fl);
      @(negedge clk);
      tb_id    = id;
      tb_start = st;
      tb_n     = n;
      tb_fl    = fl;
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [5:0] stall, input logic fl,
                           input logic done, input logic busy);
      chk({tag, "_stall"}, 32'(bus.stall), 32'(stall));
      chk({tag, "_flush"}, 32'(bus.flush), 32'(fl));
      chk({tag, "_done"},  32'(bus.ex_mc_done), 32'(done));
      chk({tag, "_busy"},  32'(bus.busy), 32'(busy));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      tb_id = 1'b0; tb_start = 1'b0; tb_n = 6'd0; tb_fl = 1'b0;

      // Reset held with random inputs
      for (int i = 0; i < 3; i++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
         chk("rst_busy", 32'(bus.busy), 32'd0);
         chk("rst_done", 32'(bus.ex_mc_done), 32'd0);
         chk("rst_flush", 32'(bus.flush), 32'd0);
         chk("rst_perf", bus.stall_cycles, 32'd0);
      end
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("post_rst", 6'h00, 1'b0, 1'b0, 1'b0);
      chk("post_rst_state", 32'(bus.dbg_state), 32'd0);
      chk("post_rst_perf", bus.stall_cycles, 32'd0);

      // Load-use stall for one cycle
      cyc(1'b1, 1'b0, 6'd0, 1'b0);
      chk_outs("lu", 6'h07, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("lu_after", 6'h00, 1'b0, 1'b0, 1'b0);
      chk("lu_perf", bus.stall_cycles, 32'd1);

      // Divide N=4: four stalled cycles, busy on the last three, then done
      cyc(1'b0, 1'b1, 6'd4, 1'b0);
      chk_outs("div0", 6'h0F, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i < 4; i++) begin
         // A load-use request while busy must not lower the stall mask
         cyc(1'b1, 1'b0, 6'd0, 1'b0);
         chk_outs("div_busy", 6'h0F, 1'b0, 1'b0, 1'b1);
      end
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("div_done", 6'h00, 1'b0, 1'b1, 1'b0);
      chk("div_perf", bus.stall_cycles, 32'd5);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("div_idle", 6'h00, 1'b0, 1'b0, 1'b0);

      // Short ops N=0 and N=1
      for (int k = 0; k < 2; k++) begin
         cyc(1'b0, 1'b1, 6'(k), 1'b0);
         chk_outs("short_start", 6'h0F, 1'b0, 1'b0, 1'b0);
         cyc(1'b0, 1'b0, 6'd0, 1'b0);
         chk_outs("short_done", 6'h00, 1'b0, 1'b1, 1'b0);
         cyc(1'b0, 1'b0, 6'd0, 1'b0);
         chk_outs("short_idle", 6'h00, 1'b0, 1'b0, 1'b0);
      end
      chk("short_perf", bus.stall_cycles, 32'd7);

      // Flush while MC_BUSY with cnt=2
      cyc(1'b0, 1'b1, 6'd3, 1'b0);
      chk_outs("fb_start", 6'h0F, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b1);
      chk("fb_cnt", 32'(bus.dbg_cnt), 32'd2);
      chk_outs("fb_req", 6'h00, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("fb_flush", 6'h00, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("fb_after1", 6'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("fb_after2", 6'h00, 1'b0, 1'b0, 1'b0);
      chk("fb_perf", bus.stall_cycles, 32'd8);

      // Flush together with a start and a load-use in IDLE: flush wins
      cyc(1'b1, 1'b1, 6'd5, 1'b1);
      chk_outs("fs_req", 6'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 6'd5, 1'b1);
      chk_outs("fs_hold", 6'h00, 1'b1, 1'b0, 1'b0);
      chk("fs_cnt", 32'(bus.dbg_cnt), 32'd0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("fs_flush", 6'h00, 1'b1, 1'b0, 1'b0);
      chk("fs_cnt2", 32'(bus.dbg_cnt), 32'd0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("fs_idle", 6'h00, 1'b0, 1'b0, 1'b0);
      chk("fs_perf", bus.stall_cycles, 32'd8);

      // Asynchronous reset in the middle of an op
      cyc(1'b0, 1'b1, 6'd8, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk("ar_busy_before", 32'(bus.busy), 32'd1);
      #1 rst = 1'b0;
      #1;
      chk_outs("ar_async", 6'h00, 1'b0, 1'b0, 1'b0);
      chk("ar_state", 32'(bus.dbg_state), 32'd0);
      chk("ar_perf", bus.stall_cycles, 32'd0);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk_outs("ar_after", 6'h00, 1'b0, 1'b0, 1'b0);

      // Saturation of the 4-bit counter
      for (int i = 0; i < 20; i++) begin
         cyc(1'b1, 1'b0, 6'd0, 1'b0);
         chk("sat_step", 32'(bus_s.stall_cycles), (i < 15) ? 32'(i) : 32'd15);
      end
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk("sat_final", 32'(bus_s.stall_cycles), 32'd15);
      chk("sat_wide", bus.stall_cycles, 32'd20);
      cyc(1'b1, 1'b0, 6'd0, 1'b0);
      cyc(1'b0, 1'b0, 6'd0, 1'b0);
      chk("sat_hold", 32'(bus_s.stall_cycles), 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
